cook_time_entry: RTL and testbench
==================================

// Module: cook_time_entry
// PURPOSE
//   Keypad-side programming front end for the countdown timer block.
//   Collects BCD digits microwave-style (shift-left entry) and drives the
//   timer's *_prog digits and load strobe. Runs the start/pause/cancel/done
//   control FSM that gates the timer's main_enable.
// PARAMETERS
//   MAX_DIGITS   4  digits accepted before further digit keys are ignored (1..4)
//   ALLOW_PAUSE  1  1: start key in RUN pauses; 0: start key in RUN ignored
// PORTS
//   clk                in   1  system clock, all state on rising edge
//   reset_n            in   1  asynchronous, active-low reset
//   key_valid          in   1  single-cycle strobe, key_code valid (pre-debounced)
//   key_code           in   4  0x0-0x9 digit, 0xA clear, 0xB start/pause, 0xC cancel, others ignored
//   timer_done         in   1  timer reached 00:00 (level or pulse; sampled per cycle)
//   seconds_prog       out  4  BCD seconds digit to timer
//   tens_seconds_prog  out  4  BCD tens-of-seconds digit to timer
//   minutes_prog       out  4  BCD minutes digit to timer
//   tens_minutes_prog  out  4  BCD tens-of-minutes digit to timer
//   load               out  1  one-cycle pulse; timer captures *_prog
//   main_enable        out  1  high while counting (RUN)
//   entry_active       out  1  high in ENTRY
//   error              out  1  one-cycle pulse on rejected start
// BEHAVIOUR
//   Reset: all digits 0, load=0, main_enable=0, entry_active=0, error=0, state IDLE.
//   States: IDLE, ENTRY, RUN, PAUSE, DONE. All outputs registered.
//   Digit key (IDLE/ENTRY): digits shift left (s->ts->m->tm, old tm dropped),
//     new key into seconds_prog; visible the cycle after key_valid; state ENTRY.
//     Internal digit count saturates at MAX_DIGITS; further digits ignored.
//   Clear (0xA) in ENTRY: digits and count zeroed, stay ENTRY. Elsewhere ignored.
//   Start in ENTRY:
//     all four digits 0        -> ignored, no error.
//     tens_seconds_prog > 5    -> error pulse next cycle, stay ENTRY
//                                 (see CONFIGURATION).
//     otherwise                -> load=1 for exactly one cycle (cycle after key),
//                                 main_enable=1 from that same cycle, state RUN.
//     *_prog held stable while load=1 and through RUN/PAUSE.
//   RUN: digit/clear keys ignored; start -> PAUSE (main_enable=0 next cycle) if
//     ALLOW_PAUSE; cancel -> IDLE, digits zeroed, main_enable=0.
//   PAUSE: start -> RUN, main_enable=1, no load; cancel -> IDLE, zeroed.
//   timer_done in RUN -> DONE, main_enable=0 next cycle. Same-cycle key_valid
//     is dropped (done wins).
//   DONE: any valid key -> IDLE, digits zeroed; that key is not consumed as a digit.
//   timer_done outside RUN ignored. Async reset at any point -> reset state;
//     an in-flight load pulse is aborted.
// CONFIGURATION
//   `NORMALIZE_EN defined: start with tens_seconds 6..9 is normalized, not rejected:
//     tens_seconds -= 6, minutes += 1 with BCD carry into tens_minutes; the
//     corrected digits drive *_prog in the same cycle as load. If
//     tens_minutes=9 and minutes=9, error pulse and stay ENTRY.
//   `NORMALIZE_EN undefined: tens_seconds > 5 always gives error, no load.
// TESTING
//   reset_n low mid-RUN -> all outputs 0 next edge-independent, state IDLE
//   keys 1,2,3,0,start -> prog 12:30, load 1 cycle, main_enable=1, entry_active=0
//   keys 1,2,3,4,5 -> prog 12:34 (5th ignored), MAX_DIGITS=4
//   keys 9,0,start, no macro -> error pulse, no load; with NORMALIZE_EN -> 01:30 loaded
//   RUN, start, start -> main_enable 1->0->1, load never re-asserted
//   RUN, timer_done with key_valid(5) same cycle -> DONE, main_enable=0, digits unchanged

Source files
------------

// File: rtl/cook_time_entry.sv
// cook_time_entry: keypad programming front end for the countdown timer.
// Collects BCD digits with microwave-style shift-left entry, drives the
// timer's *_prog digits and load strobe, and runs the
// IDLE/ENTRY/RUN/PAUSE/DONE control FSM that gates main_enable.
// Optional build macro: NORMALIZE_EN. When it is defined, a start with
// tens-of-seconds 6..9 is converted into one extra minute instead of
// being rejected.
module cook_time_entry #(
  parameter int MAX_DIGITS  = 4,
  parameter bit ALLOW_PAUSE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_done,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic       load,
  output logic       main_enable,
  output logic       entry_active,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] MAX_COUNT = 3'(MAX_DIGITS);
  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_START  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  state_t     state;
  logic [2:0] count;
  logic       is_digit;
  logic       all_zero;
  logic       ts_over;

  // Decode the current key and classify the entered time.
  always_comb begin
    is_digit = (key_code <= 4'd9);
    all_zero = ({tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} == 16'h0000);
    ts_over  = (tens_seconds_prog > 4'd5);
  end

`ifdef NORMALIZE_EN
  logic [3:0] norm_ts;
  logic [3:0] norm_m;
  logic [3:0] norm_tm;
  logic       norm_ovf;

  // Fold 60..99 seconds into one more minute, with BCD carry into tens of minutes.
  always_comb begin
    norm_ts = tens_seconds_prog - 4'd6;
    if (minutes_prog == 4'd9) begin
      norm_m   = 4'd0;
      norm_tm  = tens_minutes_prog + 4'd1;
      norm_ovf = (tens_minutes_prog == 4'd9);
    end else begin
      norm_m   = minutes_prog + 4'd1;
      norm_tm  = tens_minutes_prog;
      norm_ovf = 1'b0;
    end
  end
`endif

  // Control FSM, digit shift register and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= 3'd0;
      {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} <= 16'h0000;
      load         <= 1'b0;
      main_enable  <= 1'b0;
      entry_active <= 1'b0;
      error        <= 1'b0;
    end else begin
      load  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid && is_digit) begin
            {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} <=
              {minutes_prog, tens_seconds_prog, seconds_prog, key_code};
            count        <= 3'd1;
            state        <= ENTRY;
            entry_active <= 1'b1;
          end
        end
        ENTRY: begin
          if (key_valid) begin
            if (is_digit) begin
              // Digits beyond the limit are silently dropped.
              if (count < MAX_COUNT) begin
                {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} <=
                  {minutes_prog, tens_seconds_prog, seconds_prog, key_code};
                count <= count + 3'd1;
              end
            end else begin
              case (key_code)
                KEY_CLEAR: begin
                  {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} <= 16'h0000;
                  count <= 3'd0;
                end
                KEY_START: begin
                  if (!all_zero) begin
                    if (ts_over) begin
`ifdef NORMALIZE_EN
                      if (norm_ovf) begin
                        error <= 1'b1;
                      end else begin
                        tens_seconds_prog <= norm_ts;
                        minutes_prog      <= norm_m;
                        tens_minutes_prog <= norm_tm;
                        load              <= 1'b1;
                        main_enable       <= 1'b1;
                        entry_active      <= 1'b0;
                        state             <= RUN;
                      end
`else
                      error <= 1'b1;
`endif
                    end else begin
                      load         <= 1'b1;
                      main_enable  <= 1'b1;
                      entry_active <= 1'b0;
                      state        <= RUN;
                    end
                  end
                end
                KEY_CANCEL: begin
                  // Abandon the entry entirely.
                  {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} <= 16'h0000;
                  count        <= 3'd0;
                  entry_active <= 1'b0;
                  state        <= IDLE;
                end
                default: begin
                end
              endcase
            end
          end
        end
        RUN: begin
          // Completion outranks any key arriving in the same cycle.
          if (timer_done) begin
            main_enable <= 1'b0;
            state       <= DONE;
          end else if (key_valid) begin
            if ((key_code == KEY_START) && ALLOW_PAUSE) begin
              main_enable <= 1'b0;
              state       <= PAUSE;
            end else if (key_code == KEY_CANCEL) begin
              {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} <= 16'h0000;
              count       <= 3'd0;
              main_enable <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        PAUSE: begin
          if (key_valid) begin
            if (key_code == KEY_START) begin
              main_enable <= 1'b1;
              state       <= RUN;
            end else if (key_code == KEY_CANCEL) begin
              {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} <= 16'h0000;
              count <= 3'd0;
              state <= IDLE;
            end
          end
        end
        DONE: begin
          // Any key acknowledges completion; it is not taken as a digit.
          if (key_valid) begin
            {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} <= 16'h0000;
            count <= 3'd0;
            state <= IDLE;
          end
        end
        default: begin
          {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} <= 16'h0000;
          count        <= 3'd0;
          main_enable  <= 1'b0;
          entry_active <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cook_time_entry.sv
// Scoreboard bench for cook_time_entry: the driver pushes the expected
// output snapshot for every cycle, a monitor pops and compares after each edge.
module tb_cook_time_entry;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       timer_done;
  logic [3:0] seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog;
  logic       load, main_enable, entry_active, error;

  cook_time_entry dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .key_valid         (key_valid),
    .key_code          (key_code),
    .timer_done        (timer_done),
    .seconds_prog      (seconds_prog),
    .tens_seconds_prog (tens_seconds_prog),
    .minutes_prog      (minutes_prog),
    .tens_minutes_prog (tens_minutes_prog),
    .load              (load),
    .main_enable       (main_enable),
    .entry_active      (entry_active),
    .error             (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] tm;
    logic [3:0] m;
    logic [3:0] ts;
    logic [3:0] s;
    logic       ld;
    logic       me;
    logic       ea;
    logic       er;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: the entered time is a decimal number mmss.
  localparam int M_IDLE = 0, M_ENTRY = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
  localparam int MAXD = 4;
  int mode, val, cnt;
  bit m_load, m_err;

  function automatic void model_reset();
    mode = M_IDLE; val = 0; cnt = 0; m_load = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit kv, input int kc, input bit td);
    int mm, ss;
    m_load = 0; m_err = 0;
    if (mode == M_IDLE) begin
      if (kv && kc <= 9) begin val = kc; cnt = 1; mode = M_ENTRY; end
    end else if (mode == M_ENTRY) begin
      if (kv) begin
        if (kc <= 9) begin
          if (cnt < MAXD) begin val = (val * 10 + kc) % 10000; cnt++; end
        end else if (kc == 10) begin
          val = 0; cnt = 0;
        end else if (kc == 11) begin
          if (val != 0) begin
            mm = val / 100; ss = val % 100;
            if (ss >= 60) begin
`ifdef NORMALIZE_EN
              if (mm == 99) m_err = 1;
              else begin val = (mm + 1) * 100 + (ss - 60); m_load = 1; mode = M_RUN; end
`else
              m_err = 1;
`endif
            end else begin
              m_load = 1; mode = M_RUN;
            end
          end
        end else if (kc == 12) begin
          val = 0; cnt = 0; mode = M_IDLE;
        end
      end
    end else if (mode == M_RUN) begin
      if (td) mode = M_DONE;
      else if (kv && kc == 11) mode = M_PAUSE;
      else if (kv && kc == 12) begin val = 0; cnt = 0; mode = M_IDLE; end
    end else if (mode == M_PAUSE) begin
      if (kv && kc == 11) mode = M_RUN;
      else if (kv && kc == 12) begin val = 0; cnt = 0; mode = M_IDLE; end
    end else begin
      if (kv) begin val = 0; cnt = 0; mode = M_IDLE; end
    end
  endfunction

  function automatic snap_t model_out();
    snap_t e;
    e.s  = 4'(val % 10);
    e.ts = 4'((val / 10) % 10);
    e.m  = 4'((val / 100) % 10);
    e.tm = 4'(val / 1000);
    e.ld = m_load;
    e.me = (mode == M_RUN);
    e.ea = (mode == M_ENTRY);
    e.er = m_err;
    return e;
  endfunction

  // One stimulus cycle: drive at the falling edge, record the expectation.
  task automatic cyc(input bit kv, input int kc, input bit td);
    @(negedge clk);
    key_valid  = kv;
    key_code   = 4'(kc);
    timer_done = td;
    model_step(kv, kc, td);
    exp_q.push_back(model_out());
  endtask

  task automatic press(input int kc);
    cyc(1'b1, kc, 1'b0);
    cyc(1'b0, 0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear immediately.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    key_valid = 1'b0; timer_done = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
         load, main_enable, entry_active, error} !== 20'h0) begin
      failures++;
      $display("FAIL async_reset actual s=%0h ts=%0h m=%0h tm=%0h ld=%0b me=%0b ea=%0b er=%0b required all zero",
               seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
               load, main_enable, entry_active, error);
    end
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: every cycle with a pending expectation is compared after the edge.
  always @(posedge clk) begin
    snap_t e, a;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.s = seconds_prog; a.ts = tens_seconds_prog; a.m = minutes_prog; a.tm = tens_minutes_prog;
      a.ld = load; a.me = main_enable; a.ea = entry_active; a.er = error;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t actual %0h%0h:%0h%0h ld=%0b me=%0b ea=%0b er=%0b required %0h%0h:%0h%0h ld=%0b me=%0b ea=%0b er=%0b",
                 $time, a.tm, a.m, a.ts, a.s, a.ld, a.me, a.ea, a.er,
                 e.tm, e.m, e.ts, e.s, e.ld, e.me, e.ea, e.er);
      end
    end
  end

  initial begin
    int r, c, kc;
    bit kv, td;
    reset_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; timer_done = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
         load, main_enable, entry_active, error} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state actual %0h%0h:%0h%0h ld=%0b me=%0b ea=%0b er=%0b required all zero",
               tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog,
               load, main_enable, entry_active, error);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // 12:30, start, pause/resume, done with a same-cycle digit, acknowledge.
    press(1); press(2); press(3); press(0); press(11);
    cyc(0, 0, 0);
    press(11); press(11);
    cyc(1, 5, 1); cyc(0, 0, 0);
    press(7);
    // Digit saturation, then done and acknowledge with an unused code.
    press(1); press(2); press(3); press(4); press(5); press(11);
    cyc(0, 0, 1); cyc(0, 0, 0); press(13);
    // Tens-of-seconds over range, then cancel out of whatever results.
    press(9); press(0); press(11); press(12); press(12);
    // 99:90 cannot be normalized; all-zero start ignored; clear.
    press(9); press(9); press(9); press(0); press(11);
    press(10); press(0); press(0); press(11); press(12);
    // Timer done ignored outside RUN.
    press(4); cyc(0, 0, 1); press(11); press(11); cyc(0, 0, 1); press(11);
    // Reset mid-RUN.
    press(5); press(11); cyc(0, 0, 0);
    mid_reset();
    press(8); press(11); cyc(0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      kv = (r < 45);
      c  = $urandom_range(0, 19);
      if (c < 12)       kc = c % 10;
      else if (c < 15)  kc = 11;
      else if (c == 15) kc = 10;
      else if (c == 16) kc = 12;
      else              kc = 13 + (c - 17);
      td = ($urandom_range(0, 19) == 0);
      cyc(kv, kc, td);
    end

    cyc(0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
